// File: rtl/neg_unit_arbiter_if.sv
// Requester, shared-unit and response signals of the round-robin math-unit arbiter.
// The arbiter takes the slave side; requesters, the unit and the bench take the master side.
interface neg_unit_arbiter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic                     en;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         unit_a;
  logic [WIDTH-1:0]         unit_b;
  logic                     unit_valid;
  logic [WIDTH-1:0]         unit_z;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_z;
  logic [ID_W:0]            in_flight;
  logic                     idle;

  modport master (
    output en, req_valid, req_a, req_b, unit_z,
    input  req_ready, unit_a, unit_b, unit_valid, rsp_valid, rsp_z, in_flight, idle
  );

  modport slave (
    input  en, req_valid, req_a, req_b, unit_z,
    output req_ready, unit_a, unit_b, unit_valid, rsp_valid, rsp_z, in_flight, idle
  );
endinterface

// File: rtl/neg_unit_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, non-stalling math unit between NUM_REQ requesters.
// A {valid, id} tag pipeline follows each op through the unit and steers its result back.
module neg_unit_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned LATENCY = 1
) (
  input logic                clk,
  input logic                rst,
  neg_unit_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = ID_W + 1;

  logic [ID_W-1:0]                last_q;
  logic                           hi_hit_c, lo_hit_c, grant_c, retire_c;
  logic [ID_W-1:0]                hi_idx_c, lo_idx_c, gidx_c;
  logic [WIDTH-1:0]               sel_a_c, sel_b_c;
  logic [WIDTH-1:0]               unit_a_q, unit_b_q, rsp_z_q;
  logic                           unit_valid_q;
  logic [LATENCY:0]               tag_v_q;
  logic [LATENCY:0][ID_W-1:0]     tag_id_q;
  logic [NUM_REQ-1:0]             rsp_valid_q, rsp_onehot_c;
  logic [CNT_W-1:0]               in_flight_q;

  // Round-robin search: lowest valid index above last wins, else lowest at or below it.
  always_comb begin
    hi_hit_c = 1'b0;
    lo_hit_c = 1'b0;
    hi_idx_c = '0;
    lo_idx_c = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (bus.en && bus.req_valid[i]) begin
        if (i > int'(last_q)) begin
          hi_hit_c = 1'b1;
          hi_idx_c = ID_W'(i);
        end else begin
          lo_hit_c = 1'b1;
          lo_idx_c = ID_W'(i);
        end
      end
    end
    grant_c = hi_hit_c | lo_hit_c;
    gidx_c  = hi_hit_c ? hi_idx_c : lo_idx_c;
  end

  // Grant decode and operand select for the winning requester.
  always_comb begin
    bus.req_ready = '0;
    sel_a_c       = '0;
    sel_b_c       = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.req_ready[i] = grant_c && (gidx_c == ID_W'(i));
      if (gidx_c == ID_W'(i)) begin
        sel_a_c = bus.req_a[i*WIDTH +: WIDTH];
        sel_b_c = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // The last tag stage lines up with unit_z for the op it describes.
  always_comb begin
    retire_c     = tag_v_q[LATENCY];
    rsp_onehot_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rsp_onehot_c[i] = retire_c && (tag_id_q[LATENCY] == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= ID_W'(NUM_REQ - 1);
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      unit_valid_q <= 1'b0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_z_q      <= '0;
      in_flight_q  <= '0;
    end else begin
      if (grant_c) begin
        last_q   <= gidx_c;
        unit_a_q <= sel_a_c;
        unit_b_q <= sel_b_c;
      end
      unit_valid_q <= grant_c;
      tag_v_q      <= {tag_v_q[LATENCY-1:0], grant_c};
      tag_id_q     <= {tag_id_q[LATENCY-1:0], gidx_c};
      rsp_valid_q  <= rsp_onehot_c;
      if (retire_c) begin
        rsp_z_q <= bus.unit_z;
      end
      // Simultaneous issue and retire leave the count unchanged.
      case ({grant_c, retire_c})
        2'b10:   in_flight_q <= in_flight_q + CNT_W'(1);
        2'b01:   in_flight_q <= in_flight_q - CNT_W'(1);
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  assign bus.unit_a     = unit_a_q;
  assign bus.unit_b     = unit_b_q;
  assign bus.unit_valid = unit_valid_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.in_flight  = in_flight_q;
  assign bus.idle       = (in_flight_q == '0) && (rsp_valid_q == '0);
endmodule

// File: tb/tb_neg_unit_arbiter.sv
// Drives a LATENCY=1 and a LATENCY=3 arbiter with identical stimulus, each behind a negate unit,
// and compares them every cycle against an issue-history reference model.
module tb_neg_unit_arbiter;
  localparam int unsigned W   = 32;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int          HMAX = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;

  neg_unit_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW)) b1 ();
  neg_unit_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW)) b3 ();

  assign b1.en = en;  assign b1.req_valid = req_valid;  assign b1.req_a = req_a;  assign b1.req_b = req_b;
  assign b3.en = en;  assign b3.req_valid = req_valid;  assign b3.req_a = req_a;  assign b3.req_b = req_b;

  // Negate units of latency 1 and 3.
  logic [W-1:0] p1;
  logic [W-1:0] p3 [3];
  always_ff @(posedge clk) p1 <= -b1.unit_a;
  always_ff @(posedge clk) begin
    p3[0] <= -b3.unit_a;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.unit_z = p1;
  assign b3.unit_z = p3[2];

  neg_unit_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  neg_unit_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: edge-indexed issue history; responses and occupancy follow from it.
  int           cyc;
  int           m_last;
  logic [N-1:0] held;
  bit           hv [HMAX];
  int           hid[HMAX];
  logic [W-1:0] hz [HMAX];
  logic         e_uv;
  logic [W-1:0] e_ua, e_ub;
  logic [N-1:0] e_rv [2];
  logic [W-1:0] e_rz [2];
  int           e_inf[2];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int pick(input logic en_v, input logic [N-1:0] v);
    for (int d = 1; d <= int'(N); d++) begin
      int i;
      i = (m_last + d) % int'(N);
      if (en_v && v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    cyc = 0; m_last = int'(N) - 1; held = '0;
    e_uv = 1'b0; e_ua = '0; e_ub = '0;
    for (int k = 0; k < 2; k++) begin
      e_rv[k] = '0; e_rz[k] = '0; e_inf[k] = 0;
    end
    for (int h = 0; h < HMAX; h++) hv[h] = 1'b0;
  endtask

  task automatic model_edge(input int g, input logic [W-1:0] a, input logic [W-1:0] b);
    cyc++;
    hv[cyc]  = (g >= 0);
    hid[cyc] = g;
    hz[cyc]  = -a;
    e_uv = (g >= 0);
    if (g >= 0) begin
      e_ua = a; e_ub = b; m_last = g;
    end
    for (int k = 0; k < 2; k++) begin
      int src;
      int n;
      src = cyc - lat(k) - 1;
      if (src >= 1 && hv[src]) begin
        e_rv[k] = N'(1) << hid[src];
        e_rz[k] = hz[src];
      end else begin
        e_rv[k] = '0;
      end
      n = 0;
      for (int e = cyc - lat(k); e <= cyc; e++) if (e >= 1 && hv[e]) n++;
      e_inf[k] = n;
    end
  endtask

  task automatic check_outs();
    chk("l1.unit_valid", 64'(b1.unit_valid), 64'(e_uv));
    chk("l3.unit_valid", 64'(b3.unit_valid), 64'(e_uv));
    chk("l1.unit_a", 64'(b1.unit_a), 64'(e_ua));
    chk("l3.unit_a", 64'(b3.unit_a), 64'(e_ua));
    chk("l1.unit_b", 64'(b1.unit_b), 64'(e_ub));
    chk("l3.unit_b", 64'(b3.unit_b), 64'(e_ub));
    chk("l1.rsp_valid", 64'(b1.rsp_valid), 64'(e_rv[0]));
    chk("l3.rsp_valid", 64'(b3.rsp_valid), 64'(e_rv[1]));
    chk("l1.rsp_z", 64'(b1.rsp_z), 64'(e_rz[0]));
    chk("l3.rsp_z", 64'(b3.rsp_z), 64'(e_rz[1]));
    chk("l1.in_flight", 64'(b1.in_flight), 64'(e_inf[0]));
    chk("l3.in_flight", 64'(b3.in_flight), 64'(e_inf[1]));
    chk("l1.idle", 64'(b1.idle), 64'(e_inf[0] == 0 && e_rv[0] == '0));
    chk("l3.idle", 64'(b3.idle), 64'(e_inf[1] == 0 && e_rv[1] == '0));
  endtask

  // One clock: drive from a negedge, check grant, apply the edge to the model, check outputs.
  task automatic step(input logic en_v, input logic [N-1:0] v, input int base);
    logic [N-1:0] ve, exp_rdy;
    logic [W-1:0] ga, gb;
    int           g;
    ve = v | held;
    for (int i = 0; i < int'(N); i++) begin
      if (!held[i]) begin
        req_a[i*W +: W] = (base != 0) ? W'(base + i) : W'($urandom);
        req_b[i*W +: W] = W'($urandom);
      end
    end
    en = en_v;
    req_valid = ve;
    #1;
    g = pick(en_v, ve);
    exp_rdy = '0;
    ga = '0;
    gb = '0;
    if (g >= 0) begin
      exp_rdy = N'(1) << g;
      ga = req_a[g*W +: W];
      gb = req_b[g*W +: W];
    end
    chk("l1.req_ready", 64'(b1.req_ready), 64'(exp_rdy));
    chk("l3.req_ready", 64'(b3.req_ready), 64'(exp_rdy));
    @(posedge clk);
    model_edge(g, ga, gb);
    held = ve & ~exp_rdy;
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    req_valid = '0;
    model_clear();
    #1;
    check_outs();
    chk("rst.req_ready", 64'(b1.req_ready), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    #2;
    do_reset();

    // Single op, a=5 from requester 0.
    step(1'b1, 4'b0001, 5);
    chk("t1.unit_a", 64'(b1.unit_a), 64'd5);
    step(1'b1, 4'b0000, 0);
    step(1'b1, 4'b0000, 0);
    chk("t1.rsp_valid", 64'(b1.rsp_valid), 64'h1);
    chk("t1.rsp_z", 64'(b1.rsp_z), 64'hFFFF_FFFB);
    step(1'b1, 4'b0000, 0);
    chk("t1.idle", 64'(b1.idle), 64'h1);

    // Back-to-back ops 10, 11, 12 from requester 1 through the latency-3 unit.
    step(1'b1, 4'b0010, 9);
    step(1'b1, 4'b0010, 10);
    step(1'b1, 4'b0010, 11);
    step(1'b1, 4'b0000, 0);
    step(1'b1, 4'b0000, 0);
    chk("t6.rsp0", 64'({b3.rsp_valid, b3.rsp_z}), {28'd0, 4'b0010, 32'hFFFF_FFF6});
    step(1'b1, 4'b0000, 0);
    chk("t6.rsp1", 64'({b3.rsp_valid, b3.rsp_z}), {28'd0, 4'b0010, 32'hFFFF_FFF5});
    step(1'b1, 4'b0000, 0);
    chk("t6.rsp2", 64'({b3.rsp_valid, b3.rsp_z}), {28'd0, 4'b0010, 32'hFFFF_FFF4});
    repeat (3) step(1'b1, 4'b0000, 0);

    // All requesters asserted from reset with operands 1..4.
    do_reset();
    repeat (10) step(1'b1, 4'b1111, 1);

    // Fairness after serving requester 2.
    repeat (4) step(1'b1, 4'b0000, 0);
    step(1'b1, 4'b0100, 0);
    repeat (4) step(1'b1, 4'b1111, 0);

    // Enable gating with everyone requesting, then resume.
    repeat (5) step(1'b0, 4'b1111, 0);
    repeat (3) step(1'b1, 4'b1111, 0);

    // Reset with two ops in flight, then first grant goes to requester 0.
    repeat (6) step(1'b1, 4'b0000, 0);
    step(1'b1, 4'b0011, 0);
    step(1'b1, 4'b0011, 0);
    do_reset();
    repeat (3) step(1'b1, 4'b0000, 0);
    step(1'b1, 4'b1111, 0);

    // Randomized traffic with occasional enable drops.
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 7) != 0), N'($urandom), 0);
    end

    repeat (12) step(1'b1, 4'b0000, 0);
    chk("end.idle1", 64'(b1.idle), 64'h1);
    chk("end.idle3", 64'(b3.idle), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neg_unit_arbiter.md
Name: neg_unit_arbiter

Overview:
Round-robin arbiter that shares one fixed-latency, non-stalling math unit (neg, add or similar) between NUM_REQ requesters.
- Accepts operands via valid/ready handshakes and issues at most one operation per clock into the unit.
- Tracks each in-flight operation's requester ID in a tag pipeline aligned to the unit latency.
- Routes each result back to its originating requester.
- Sits between client pipelines and a shared unit in the math component library.

Parameters:
WIDTH, 32, operand/result width in bits
NUM_REQ, 4, number of requesters
ID_W, 2, requester ID width; 2**ID_W >= NUM_REQ required
LATENCY, 1, unit latency in clocks from unit_a/unit_b sampled to unit_z valid (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  grant enable; 0 blocks new grants, in-flight ops complete
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant, combinational, at most one bit set
req_a  input  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand B, same packing; unary units ignore it
unit_a  output  WIDTH  registered operand A to unit
unit_b  output  WIDTH  registered operand B to unit
unit_valid  output  1  registered; unit_a/unit_b hold a live op
unit_z  input  WIDTH  unit result
rsp_valid  output  NUM_REQ  registered one-hot response strobe
rsp_z  output  WIDTH  registered result, shared by all requesters
in_flight  output  ID_W+1  count of issued ops whose response is not yet delivered
idle  output  1  high when in_flight==0 and rsp_valid==0

Behaviour:
- **Reset values:** unit_a=0, unit_b=0, unit_valid=0, rsp_valid=0, rsp_z=0, in_flight=0, idle=1. Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority. All tag stages are cleared.
- **Arbitration:**
  - req_ready[i]=1 iff en=1 and req_valid[i]=1 and i is the first valid requester searching last+1, last+2 … modulo NUM_REQ.
  - req_ready never depends on unit or response state.
  - Handshake completes on an edge with req_valid[i]&req_ready[i].
  - Requesters hold req_a/req_b stable while valid and not ready.
- **Pointer:** last<=granted index on a handshake edge; otherwise unchanged.
- **Issue:** on a handshake edge E0, unit_a/unit_b<=granted operands and unit_valid<=1. With no handshake, unit_valid<=0 and the operand registers hold their values. Throughput is one op per clock.
- **Tag pipeline:** LATENCY+1 stages of {valid, ID}.
  - Stage 0 is loaded at E0.
  - It shifts every clock, with no stall.
  - The final stage aligns with unit_z valid.
- **Response:**
  - At edge E0+LATENCY+1, rsp_valid<=one-hot(ID) and rsp_z<=unit_z.
  - rsp_valid is high for exactly one cycle. rsp_z holds its value when no response is due.
  - Responses are never back-pressured. They return in issue order.
- **in_flight:**
  - Increments on a handshake.
  - Decrements on the edge the response registers load.
  - On simultaneous issue and retire it is unchanged.
  - Maximum value is LATENCY+1.
- **en=0:** no new grants. The pipeline drains normally, and idle rises after the last rsp_valid pulse.
- **Reset mid-operation:** async clear of all state. In-flight ops are discarded and no rsp_valid is generated for them. The pointer returns to NUM_REQ-1.
- **Single requester:** a continuously valid requester is granted every clock; fairness is still round-robin once others assert.
- **ID out of range:** impossible by construction; there is no error output.

Test Plan:
1. Single op, neg unit (LATENCY=1): req_valid=0001, req_a[0]=5 → req_ready=0001 same cycle; unit_a=5 after E0; rsp_valid=0001 and rsp_z=0xFFFFFFFB for one cycle after edge E0+2; idle returns to 1.
2. All-assert from reset: req_valid=1111 held, distinct operands 1,2,3,4 → grants 0,1,2,3,0… one per clock; responses -1,-2,-3,-4 in the same order, one per clock, each strobing the matching rsp_valid bit; in_flight peaks at 2.
3. Fairness: grant requester 2, then req_valid=1111 → next grant 3, then 0; requester 2 is not granted again until 3, 0 and 1 are each served once.
4. Enable gating: en=0 with req_valid=1111 for 5 clocks → req_ready=0000 and unit_valid=0; in-flight ops still respond; set en=1 → grants resume from pointer+1.
5. Reset mid-flight: issue 2 ops, assert rst before their responses → rsp_valid stays 0000 throughout and after; in_flight=0; next request after reset is granted to requester 0 first.
6. LATENCY=3 configuration: back-to-back ops from requester 1 with operands 10,11,12 → rsp_valid[1] pulses for 3 consecutive cycles, starting after edge E0+4, with rsp_z = -10, -11, -12.
